la_capture_ctrl: RTL and testbench

Capture sequencer for the 4-channel logic analyzer. It divides the system clock down to a selectable sample rate and arms capture in free-run or triggered mode. It writes one frame of samples into the sample buffer RAM, then hands the frame to the OLED display renderer with a valid/ack handshake. It also implements the freeze function: hold the last displayed frame and stop capturing.

---
 rtl/la_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_la_capture_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/la_capture_ctrl.sv
// Capture sequencer for the 4-channel logic analyzer: rate divider, free-run/trigger
// arming, one-frame buffer fill, valid/ack handoff to the renderer, and freeze/hold.
module la_capture_ctrl #(
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 7,
  parameter int DIV_SLOW = 100000,
  parameter int DIV_FAST = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        logic_in_external,
  input  logic              speed_switch,
  input  logic              mode_select,
  input  logic              freeze_button,
  input  logic              frame_ack,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [3:0]        buf_wdata,
  output logic              frame_valid,
  output logic              frozen
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CNT_W   = $clog2(DIV_MAX);
  localparam logic [CNT_W-1:0]  TOP_SLOW  = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0]  TOP_FAST  = CNT_W'(DIV_FAST - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_ARM,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_HANDOFF,
    ST_HOLD
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_s_q;
  logic              r_fb_q;
  logic              r_spd_q;
  logic              r_prev_ch0, w_prev_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;
  logic              r_we, w_we_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [3:0]        r_wdata, w_wdata_next;
  logic              r_fv, w_fv_next;
  logic              r_frozen;

  logic              w_press;
  logic              w_frozen_next;
  logic              w_spd_chg;
  logic [CNT_W-1:0]  w_top;
  logic              w_tick;

  assign w_press       = freeze_button & ~r_fb_q;
  assign w_frozen_next = r_frozen ^ w_press;
  assign w_spd_chg     = speed_switch ^ r_spd_q;
  assign w_top         = speed_switch ? TOP_FAST : TOP_SLOW;
  // A rate change in the same cycle as a tick wins: no sample is taken.
  assign w_tick        = (r_cnt == w_top) && !w_spd_chg;

  // speed_switch is tracked even in reset so release never looks like a change.
  always_ff @(posedge clk) begin
    r_spd_q <= speed_switch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARM;
      r_cnt      <= '0;
      r_s_q      <= '0;
      r_fb_q     <= 1'b1;
      r_prev_ch0 <= 1'b0;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fv       <= 1'b0;
      r_frozen   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_s_q      <= logic_in_external;
      r_fb_q     <= freeze_button;
      r_prev_ch0 <= w_prev_next;
      r_ptr      <= w_ptr_next;
      r_we       <= w_we_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_fv       <= w_fv_next;
      r_frozen   <= w_frozen_next;
      if (r_state == ST_ARM || w_spd_chg || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_prev_next  = r_prev_ch0;
    w_ptr_next   = r_ptr;
    w_we_next    = 1'b0;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_fv_next    = 1'b0;
    case (r_state)
      ST_ARM: begin
        w_addr_next = '0;
        w_ptr_next  = '0;
        w_prev_next = r_s_q[0];
        if (w_frozen_next)
          w_state_next = ST_HOLD;
        else if (mode_select)
          w_state_next = ST_WAIT_TRIG;
        else
          w_state_next = ST_CAPTURE;
      end
      ST_WAIT_TRIG: begin
        if (w_spd_chg) begin
          w_state_next = ST_ARM;
        end else if (w_frozen_next) begin
          w_state_next = ST_HOLD;
        end else if (w_tick) begin
          w_prev_next = r_s_q[0];
          // The trigger sample itself becomes buffer entry 0.
          if (r_s_q[0] && !r_prev_ch0) begin
            w_we_next    = 1'b1;
            w_addr_next  = '0;
            w_wdata_next = r_s_q;
            w_ptr_next   = ADDR_W'(1);
            w_state_next = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (w_spd_chg) begin
          w_state_next = ST_ARM;
        end else if (w_tick) begin
          w_we_next    = 1'b1;
          w_addr_next  = r_ptr;
          w_wdata_next = r_s_q;
          w_ptr_next   = r_ptr + ADDR_W'(1);
          if (r_ptr == LAST_ADDR)
            w_state_next = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        w_addr_next = '0;
        w_fv_next   = 1'b1;
        // Only an ack seen while valid is visible counts.
        if (r_fv && frame_ack) begin
          w_fv_next    = 1'b0;
          w_state_next = w_frozen_next ? ST_HOLD : ST_ARM;
        end
      end
      ST_HOLD: begin
        if (!r_frozen)
          w_state_next = ST_ARM;
      end
      default: w_state_next = ST_ARM;
    endcase
  end

  assign buf_we      = r_we;
  assign buf_addr    = r_addr;
  assign buf_wdata   = r_wdata;
  assign frame_valid = r_fv;
  assign frozen      = r_frozen;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with DEPTH=8, DIV_FAST=4, DIV_SLOW=16.
module tb_la_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] logic_in_external;
  logic       speed_switch;
  logic       mode_select;
  logic       freeze_button;
  logic       frame_ack;
  logic       buf_we;
  logic [2:0] buf_addr;
  logic [3:0] buf_wdata;
  logic       frame_valid;
  logic       frozen;

  int n_checks = 0;
  int n_errors = 0;

  la_capture_ctrl #(
    .DEPTH(8), .ADDR_W(3), .DIV_SLOW(16), .DIV_FAST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .logic_in_external(logic_in_external),
    .speed_switch(speed_switch), .mode_select(mode_select),
    .freeze_button(freeze_button), .frame_ack(frame_ack),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .frame_valid(frame_valid), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic spd, input logic mode, input logic [3:0] din);
    rst = 1'b1;
    speed_switch = spd;
    mode_select = mode;
    logic_in_external = din;
    freeze_button = 1'b0;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance at least one cycle, then until buf_we or the budget runs out.
  task automatic wait_we(input string tag, input int max, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!buf_we && waited < max);
    if (!buf_we) check_eq({tag, "_timeout"}, 32'(buf_we), 32'd1);
    else $display("write %s addr=%0d data=%h after %0d cycles", tag, buf_addr, buf_wdata, waited);
  endtask

  task automatic expect_write(input string tag, input int max, input int exp_addr,
                              input int exp_data, input int exp_gap);
    int w;
    wait_we(tag, max, w);
    check_eq({tag, "_addr"}, 32'(buf_addr), 32'(exp_addr));
    check_eq({tag, "_data"}, 32'(buf_wdata), 32'(exp_data));
    if (exp_gap >= 0) check_eq({tag, "_gap"}, 32'(w), 32'(exp_gap));
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check_eq("ack_fv_low", 32'(frame_valid), 32'd0);
  endtask

  task automatic press();
    freeze_button = 1'b1;
    @(negedge clk);
    freeze_button = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bad, nwe;
    @(negedge clk);

    // Reset values while reset is held
    do_reset(1'b1, 1'b0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_we", 32'(buf_we), 32'd0);
    check_eq("rst_addr", 32'(buf_addr), 32'd0);
    check_eq("rst_wdata", 32'(buf_wdata), 32'd0);
    check_eq("rst_fv", 32'(frame_valid), 32'd0);
    check_eq("rst_frozen", 32'(frozen), 32'd0);
    rst = 1'b0;

    // Free-run, fast rate, data stepping 0..7
    for (int i = 0; i < 8; i++) begin
      expect_write($sformatf("free%0d", i), 20, i, i, (i == 0) ? -1 : 4);
      if (i == 7) check_eq("free_fv_at_last", 32'(frame_valid), 32'd0);
      logic_in_external = 4'(i + 1);
    end
    @(negedge clk);
    check_eq("free_fv", 32'(frame_valid), 32'd1);

    // Handshake: valid held with no writes until ack
    bad = 0;
    nwe = 0;
    repeat (50) begin
      @(negedge clk);
      if (!frame_valid) bad++;
      if (buf_we) nwe++;
    end
    check_eq("hs_fv_drop", 32'(bad), 32'd0);
    check_eq("hs_no_we", 32'(nwe), 32'd0);
    logic_in_external = 4'hC;
    ack_pulse();
    expect_write("hs_restart", 20, 0, 32'hC, 5);

    // Triggered on channel-0 rise
    do_reset(1'b1, 1'b1, 4'h0);
    nwe = 0;
    repeat (40) begin
      @(negedge clk);
      if (buf_we) nwe++;
    end
    check_eq("trig_no_early_we", 32'(nwe), 32'd0);
    logic_in_external = 4'b1011;
    wait_we("trig_first", 20, w);
    check_eq("trig_addr", 32'(buf_addr), 32'd0);
    check_eq("trig_data", 32'(buf_wdata), 32'hB);
    check_eq("trig_latency_ok", 32'(w >= 1 && w <= 6), 32'd1);
    expect_write("trig_second", 10, 1, 32'hB, 4);

    // Freeze pressed right after the address-3 write
    do_reset(1'b1, 1'b0, 4'h6);
    for (int i = 0; i < 4; i++) expect_write($sformatf("frz%0d", i), 20, i, 6, -1);
    press();
    check_eq("frz_set", 32'(frozen), 32'd1);
    for (int i = 4; i < 8; i++) expect_write($sformatf("frz%0d", i), 20, i, 6, -1);
    @(negedge clk);
    check_eq("frz_fv", 32'(frame_valid), 32'd1);
    ack_pulse();
    bad = 0;
    nwe = 0;
    repeat (200) begin
      @(negedge clk);
      if (buf_we) nwe++;
      if (frame_valid || !frozen) bad++;
    end
    check_eq("hold_no_we", 32'(nwe), 32'd0);
    check_eq("hold_flags", 32'(bad), 32'd0);
    press();
    check_eq("frz_clear", 32'(frozen), 32'd0);
    expect_write("unfrz_first", 30, 0, 6, -1);

    // Speed change after the address-3 write aborts the frame
    do_reset(1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 4; i++) expect_write($sformatf("spd%0d", i), 20, i, 5, -1);
    speed_switch = 1'b0;
    expect_write("spd_restart", 40, 0, 5, 18);
    expect_write("spd_slow1", 40, 1, 5, 16);

    // Reset during handoff
    do_reset(1'b1, 1'b0, 4'h9);
    for (int i = 0; i < 8; i++) expect_write($sformatf("rh%0d", i), 20, i, 9, -1);
    @(negedge clk);
    check_eq("rh_fv", 32'(frame_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rh_we", 32'(buf_we), 32'd0);
    check_eq("rh_addr", 32'(buf_addr), 32'd0);
    check_eq("rh_wdata", 32'(buf_wdata), 32'd0);
    check_eq("rh_fv_low", 32'(frame_valid), 32'd0);
    check_eq("rh_frozen", 32'(frozen), 32'd0);
    rst = 1'b0;
    expect_write("rh_restart", 20, 0, 9, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
